// File: rtl/noc_sched_pkg.sv
// Shared types, constants and helpers for the output-port scheduler.
package noc_sched_pkg;

   localparam int PKT_W      = 14;
   localparam int STAT_W_DEF = 16;

   typedef logic [PKT_W-1:0] packet_t;

   // Index width for n requesters; never below 1 so a 2-input build still has a pointer bit.
   function automatic int ptr_w(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

   // Saturating increment for counters up to 32 bits wide; w is the counter width.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] mx;
      mx = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= mx) ? mx : v + 32'd1;
   endfunction

endpackage

// File: rtl/out_port_sched_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping modulo NUM_IN.
module rr_pick
   import noc_sched_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int PTR_W  = ptr_w(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req_i,
   input  logic [PTR_W-1:0]  ptr_i,
   output logic [NUM_IN-1:0] gnt_o,
   output logic [PTR_W-1:0]  gnt_idx_o,
   output logic              any_o
);

   localparam int SW = PTR_W + 1;

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] sel;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_o     = 1'b0;
      sum       = '0;
      sel       = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         // ptr_i < NUM_IN, so a single subtraction keeps the scan index in range.
         sum = {1'b0, ptr_i} + SW'(k);
         if (sum >= SW'(NUM_IN)) sum = sum - SW'(NUM_IN);
         sel = sum[PTR_W-1:0];
         if (!any_o && req_i[sel]) begin
            any_o      = 1'b1;
            gnt_o[sel] = 1'b1;
            gnt_idx_o  = sel;
         end
      end
   end

endmodule

// File: rtl/out_port_sched.sv
// Round-robin output-port scheduler with a one-entry registered output stage.
// Optional per-input grant and stall counters are built when OUT_SCHED_STATS_EN is defined.
module out_port_sched
   import noc_sched_pkg::*;
#(
   parameter int WIDTH_packet = PKT_W,
   parameter int NUM_IN       = 4,
   parameter int STAT_W       = STAT_W_DEF,
   localparam int PTR_W       = ptr_w(NUM_IN)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_IN-1:0]          in_valid,
   input  logic [NUM_IN*WIDTH_packet-1:0] in_data,
   output logic [NUM_IN-1:0]          in_ready,
   output logic                       out_valid,
   output logic [WIDTH_packet-1:0]    out_data,
   output logic [PTR_W-1:0]           out_src,
   input  logic                       out_ready,
   output logic [NUM_IN*STAT_W-1:0]   stat_grant_cnt,
   output logic [STAT_W-1:0]          stat_stall_cnt
);

   logic                    out_valid_q, out_valid_d;
   logic [WIDTH_packet-1:0] out_data_q,  out_data_d;
   logic [PTR_W-1:0]        out_src_q,   out_src_d;
   logic [PTR_W-1:0]        rr_ptr_q,    rr_ptr_d;

   logic                    load_en;
   logic [NUM_IN-1:0]       gnt;
   logic [PTR_W-1:0]        gnt_idx;
   logic                    any;
   logic [WIDTH_packet-1:0] in_pkt [NUM_IN];

   for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
      assign in_pkt[i] = in_data[i*WIDTH_packet +: WIDTH_packet];
   end

   rr_pick #(
      .NUM_IN (NUM_IN),
      .PTR_W  (PTR_W)
   ) u_pick (
      .req_i     (in_valid),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (any)
   );

   // The stage can take a new packet whenever it is empty or draining this cycle.
   assign load_en  = !out_valid_q || out_ready;
   assign in_ready = (load_en && rst_n) ? gnt : '0;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      if (load_en) begin
         out_valid_d = any;
         if (any) begin
            out_data_d = in_pkt[gnt_idx];
            out_src_d  = gnt_idx;
            rr_ptr_d   = (gnt_idx == PTR_W'(NUM_IN - 1)) ? '0 : gnt_idx + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

`ifdef OUT_SCHED_STATS_EN
   logic              accept;
   logic [STAT_W-1:0] grant_cnt_q [NUM_IN];
   logic [STAT_W-1:0] stall_cnt_q;

   assign accept = load_en && any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_IN; i++) grant_cnt_q[i] <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (accept && gnt[i])
               grant_cnt_q[i] <= STAT_W'(sat_inc(32'(grant_cnt_q[i]), STAT_W));
         end
         if (out_valid_q && !out_ready)
            stall_cnt_q <= STAT_W'(sat_inc(32'(stall_cnt_q), STAT_W));
      end
   end

   for (genvar i = 0; i < NUM_IN; i++) begin : g_stat
      assign stat_grant_cnt[i*STAT_W +: STAT_W] = grant_cnt_q[i];
   end
   assign stat_stall_cnt = stall_cnt_q;
`else
   assign stat_grant_cnt = '0;
   assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_out_port_sched.sv
// Self-checking bench for out_port_sched: round-robin, backpressure, reset and NUM_IN=3 builds.
module tb_out_port_sched;
  import noc_sched_pkg::*;

  localparam int N    = 4;
  localparam int W    = 14;
  localparam int SW   = 16;
  localparam int SMAX = 65535;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  packet_t        in_pkt [N];
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;
  logic [N*SW-1:0] stat_grant_cnt;
  logic [SW-1:0]  stat_stall_cnt;

  logic [2:0]     in3_valid;
  logic [3*W-1:0] in3_data;
  logic [2:0]     in3_ready;
  logic           out3_valid;
  logic [W-1:0]   out3_data;
  logic [1:0]     out3_src;
  logic           out3_ready;
  logic [3*SW-1:0] stat3_grant;
  logic [SW-1:0]  stat3_stall;

  int n_checks;
  int n_fail;

  // reference model: pointer to the next input to favour, scoreboard of the output stage
  int m_ptr;
  int m_gcnt [N];
  int m_stall;
  int m_wait [N];
  logic [W+1:0] exp_q [$];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign in_data[i*W +: W] = in_pkt[i];
  end

  out_port_sched #(.WIDTH_packet(W), .NUM_IN(N), .STAT_W(SW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_src        (out_src),
    .out_ready      (out_ready),
    .stat_grant_cnt (stat_grant_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );

  out_port_sched #(.WIDTH_packet(W), .NUM_IN(3), .STAT_W(SW)) dut3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in3_valid),
    .in_data        (in3_data),
    .in_ready       (in3_ready),
    .out_valid      (out3_valid),
    .out_data       (out3_data),
    .out_src        (out3_src),
    .out_ready      (out3_ready),
    .stat_grant_cnt (stat3_grant),
    .stat_stall_cnt (stat3_stall)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_q.delete();
    m_ptr   = 0;
    m_stall = 0;
    for (int i = 0; i < N; i++) begin
      m_gcnt[i] = 0;
      m_wait[i] = 0;
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check the output stage after.
  task automatic cycle(output int g);
    logic         le;
    logic [N-1:0] er;
    int           idx;
    #1;
    le = (exp_q.size() == 0) || out_ready;
    g  = -1;
    if (le) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && in_valid[idx]) g = idx;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    n_checks++;
    if (in_ready !== er) begin
      n_fail++;
      $display("FAIL in_ready: got %b expected %b", in_ready, er);
    end
    @(posedge clk);
    if (exp_q.size() != 0 && !out_ready && m_stall < SMAX) m_stall++;
    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back({2'(g), in_pkt[g]});
      m_ptr = (g + 1) % N;
      if (m_gcnt[g] < SMAX) m_gcnt[g]++;
      n_checks++;
      if (m_wait[g] >= N) begin
        n_fail++;
        $display("FAIL fairness: input %0d waited %0d grants, limit %0d", g, m_wait[g], N - 1);
      end
      for (int i = 0; i < N; i++) begin
        if (i == g) m_wait[i] = 0;
        else if (in_valid[i]) m_wait[i]++;
      end
    end
    #1;
    n_checks++;
    if (out_valid !== (exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      if ({out_src, out_data} !== exp_q[0]) begin
        n_fail++;
        $display("FAIL out_pkt: got src %0d data %h expected src %0d data %h",
                 out_src, out_data, exp_q[0][W+1:W], exp_q[0][W-1:0]);
      end
    end
  endtask

  task automatic check_src(input string name, input logic [1:0] exp_src);
    n_checks++;
    if (out_src !== exp_src) begin
      n_fail++;
      $display("FAIL %s: out_src got %0d expected %0d", name, out_src, exp_src);
    end
  endtask

  task automatic test_reset();
    int g;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int i = 0; i < N; i++) in_pkt[i] = packet_t'(14'h0100 + i);
    in3_valid  = '0;
    in3_data   = '0;
    out3_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_src !== 2'd0 || in_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid %b src %0d in_ready %b expected 0 0 0", out_valid, out_src, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle(g);
    check_src("first_grant", 2'd0);
    repeat (3) cycle(g);
    // asynchronous reset in the middle of a cycle with a packet held
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_src !== 2'd0 || in_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid %b src %0d in_ready %b expected 0 0 0", out_valid, out_src, in_ready);
    end
    n_checks++;
    if (stat_grant_cnt !== '0 || stat_stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: grant %h stall %h expected 0", stat_grant_cnt, stat_stall_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_valid();
    int g;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle(g);
      check_src("rr_order", 2'(k % N));
      n_checks++;
      if (out_data !== W'(14'h0100 + k % N)) begin
        n_fail++;
        $display("FAIL rr_data: got %h expected %h", out_data, 14'h0100 + k % N);
      end
    end
  endtask

  task automatic test_wrap();
    int g;
    in_valid = 4'b0100;
    cycle(g);
    check_src("wrap_first", 2'd2);
    in_pkt[2] = packet_t'($urandom);
    cycle(g);
    check_src("wrap_again", 2'd2);
    in_valid = '0;
    cycle(g);
  endtask

  task automatic test_stall();
    int g;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    cycle(g);
    in_valid  = 4'b1010;
    in_pkt[1] = packet_t'($urandom);
    in_pkt[3] = packet_t'($urandom);
    cycle(g);
    check_src("stall_pre", 2'd1);
    in_pkt[1] = packet_t'($urandom);
    out_ready = 1'b0;
    repeat (5) cycle(g);
    out_ready = 1'b1;
    cycle(g);
    check_src("stall_release", 2'd3);
    in_valid = '0;
    cycle(g);
  endtask

  task automatic test_random();
    int g;
    for (int c = 0; c < 400; c++) begin
      cycle(g);
      if (g >= 0) begin
        in_valid[g] = 1'($urandom_range(0, 1));
        in_pkt[g]   = packet_t'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          in_valid[i] = 1'b1;
          in_pkt[i]   = packet_t'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_stats();
    logic [SW-1:0] exp_cnt;
    #1;
    for (int i = 0; i < N; i++) begin
`ifdef OUT_SCHED_STATS_EN
      exp_cnt = SW'(m_gcnt[i]);
`else
      exp_cnt = '0;
`endif
      n_checks++;
      if (stat_grant_cnt[i*SW +: SW] !== exp_cnt) begin
        n_fail++;
        $display("FAIL stat_grant[%0d]: got %0d expected %0d", i, stat_grant_cnt[i*SW +: SW], exp_cnt);
      end
    end
`ifdef OUT_SCHED_STATS_EN
    exp_cnt = SW'(m_stall);
`else
    exp_cnt = '0;
`endif
    n_checks++;
    if (stat_stall_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL stat_stall: got %0d expected %0d", stat_stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_num3();
    int          seq [4] = '{0, 2, 0, 2};
    logic [2:0]  er;
    logic [W-1:0] ed;
    for (int i = 0; i < 3; i++) in3_data[i*W +: W] = W'(14'h02A0 + i);
    in3_valid  = 3'b101;
    out3_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      er = (seq[k % 4] == 0) ? 3'b001 : 3'b100;
      n_checks++;
      if (in3_ready !== er) begin
        n_fail++;
        $display("FAIL n3_in_ready: got %b expected %b", in3_ready, er);
      end
      @(posedge clk);
      #1;
      ed = W'(14'h02A0 + seq[k % 4]);
      n_checks++;
      if (out3_valid !== 1'b1 || out3_src !== 2'(seq[k % 4]) || out3_data !== ed) begin
        n_fail++;
        $display("FAIL n3_grant: valid %b src %0d data %h expected 1 %0d %h",
                 out3_valid, out3_src, out3_data, seq[k % 4], ed);
      end
    end
    in3_valid = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_all_valid();
    test_wrap();
    test_stall();
    test_random();
    test_stats();
    test_num3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
